secuenciador_rtc: RTL and testbench

Burst-write controller that sequences the RTC register writer. On one `start` command it latches up to nine time/date/timer bytes and issues them one at a time to the writer through its `iniciar`/`final` handshake, in a fixed address order, with a per-transaction watchdog. It sits between the user/configuration logic and the single-transaction writer, which it owns exclusively while `busy` is high.

---
 rtl/secuenciador_rtc.sv | 182 ++++++++++++++++++
 tb/tb_secuenciador_rtc.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/secuenciador_rtc.sv
// secuenciador_rtc: burst-write sequencer for the RTC register writer.
// Latches up to nine time/date/timer bytes on start and issues them one
// at a time to the writer via the iniciar/final handshake, with a
// per-transaction watchdog that aborts the burst when final never comes.
//
// Ports:
//   i_clk, i_reset       clock, synchronous active-high reset
//   i_start, i_mode      burst command (00 date/time, 01 timer, 10 all)
//   i_segundo..i_anio    date/time bytes (idx 0..5)
//   i_t_segundo..i_t_hora timer bytes (idx 6..8)
//   i_wr_final           writer transaction complete
//   o_wr_iniciar         transaction request (level)
//   o_wr_dir, o_wr_dato  register address / data to writer
//   o_busy, o_done, o_err burst status (done = 1-cycle pulse, err sticky)
module secuenciador_rtc #(
    parameter int TIMEOUT = 50000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_start,
    input  logic [1:0] i_mode,
    input  logic [7:0] i_segundo,
    input  logic [7:0] i_minuto,
    input  logic [7:0] i_hora,
    input  logic [7:0] i_dia,
    input  logic [7:0] i_mes,
    input  logic [7:0] i_anio,
    input  logic [7:0] i_t_segundo,
    input  logic [7:0] i_t_minuto,
    input  logic [7:0] i_t_hora,
    input  logic       i_wr_final,
    output logic       o_wr_iniciar,
    output logic [7:0] o_wr_dir,
    output logic [7:0] o_wr_dato,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_err
);

    localparam int WDW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] WD_MAX = WDW'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WAIT    = 2'd1;
    localparam logic [1:0] S_RELEASE = 2'd2;

    logic [1:0]     r_state;
    logic [3:0]     r_idx;
    logic [3:0]     r_last;
    logic [WDW-1:0] r_wd;
    logic           r_iniciar;
    logic [7:0]     r_dir;
    logic [7:0]     r_dato;
    logic           r_busy;
    logic           r_done;
    logic           r_err;
    logic [7:0]     r_shadow [0:8];

    logic [7:0]     w_live [0:8];
    logic [3:0]     w_first;
    logic [3:0]     w_end;
    logic [3:0]     w_next_idx;
    logic           w_accept;

    assign w_live[0] = i_segundo;
    assign w_live[1] = i_minuto;
    assign w_live[2] = i_hora;
    assign w_live[3] = i_dia;
    assign w_live[4] = i_mes;
    assign w_live[5] = i_anio;
    assign w_live[6] = i_t_segundo;
    assign w_live[7] = i_t_minuto;
    assign w_live[8] = i_t_hora;

    assign w_first    = (i_mode == 2'b01) ? 4'd6 : 4'd0;
    assign w_end      = (i_mode == 2'b00) ? 4'd5 : 4'd8;
    assign w_next_idx = r_idx + 4'd1;
    assign w_accept   = (r_state == S_IDLE) && i_start && (i_mode != 2'b11);

    // Date/time block lives at 0x21.., timer block at 0x41..
    function automatic logic [7:0] f_dir(input logic [3:0] idx);
        if (idx < 4'd6)
            return 8'h21 + {4'd0, idx};
        else
            return 8'h41 + {4'd0, idx - 4'd6};
    endfunction

    // Shadow copy isolates the burst from input changes after start
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            for (int k = 0; k < 9; k++)
                r_shadow[k] <= w_live[k];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_idx     <= 4'd0;
            r_last    <= 4'd0;
            r_wd      <= '0;
            r_iniciar <= 1'b0;
            r_dir     <= 8'h00;
            r_dato    <= 8'h00;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        if (i_mode == 2'b11) begin
                            r_err  <= 1'b1;
                            r_done <= 1'b1;
                        end else begin
                            // First byte comes from live inputs: shadow
                            // is only being written this same edge
                            r_idx     <= w_first;
                            r_last    <= w_end;
                            r_err     <= 1'b0;
                            r_busy    <= 1'b1;
                            r_dir     <= f_dir(w_first);
                            r_dato    <= w_live[w_first];
                            r_iniciar <= 1'b1;
                            r_wd      <= '0;
                            r_state   <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (i_wr_final) begin
                        r_iniciar <= 1'b0;
                        r_wd      <= '0;
                        r_state   <= S_RELEASE;
                    end else if (r_wd == WD_MAX) begin
                        r_iniciar <= 1'b0;
                        r_dir     <= 8'h00;
                        r_dato    <= 8'h00;
                        r_err     <= 1'b1;
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_wd      <= '0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
                end
                S_RELEASE: begin
                    // Writer still uses dir after final; hold until it drops
                    if (!i_wr_final) begin
                        if (r_idx == r_last) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_dir   <= 8'h00;
                            r_dato  <= 8'h00;
                            r_state <= S_IDLE;
                        end else begin
                            r_idx     <= w_next_idx;
                            r_dir     <= f_dir(w_next_idx);
                            r_dato    <= r_shadow[w_next_idx];
                            r_wd      <= '0;
                            r_iniciar <= 1'b1;
                            r_state   <= S_WAIT;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_wr_iniciar = r_iniciar;
    assign o_wr_dir     = r_dir;
    assign o_wr_dato    = r_dato;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_err        = r_err;

endmodule

// File: tb/tb_secuenciador_rtc.sv
// tb_secuenciador_rtc: directed bench with a writer model and a
// scoreboard of expected (address, data) transactions.
module tb_secuenciador_rtc;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] mode;
    logic [7:0] seg, min, hor, dia, mes, ani, tseg, tmin, thor;
    logic       fin;
    logic       ini;
    logic [7:0] dir, dato;
    logic       busy, done, err;

    int checks = 0;
    int failures = 0;

    logic [15:0] exp_q [$];
    int          tx_cnt = 0;
    int          done_cnt = 0;
    int          run = 0;
    int          last_run = 0;
    int          low_cnt = 0;
    logic        prev_ini = 1'b0;
    logic        prev_busy = 1'b0;
    logic [7:0]  cap_dir, cap_dato;

    logic        wr_en;
    int          wcnt;

    secuenciador_rtc #(.TIMEOUT(20)) dut (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_mode(mode),
        .i_segundo(seg), .i_minuto(min), .i_hora(hor), .i_dia(dia),
        .i_mes(mes), .i_anio(ani), .i_t_segundo(tseg),
        .i_t_minuto(tmin), .i_t_hora(thor), .i_wr_final(fin),
        .o_wr_iniciar(ini), .o_wr_dir(dir), .o_wr_dato(dato),
        .o_busy(busy), .o_done(done), .o_err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Writer: final 5 cycles after iniciar, dropped 1 cycle after it falls
    always @(posedge clk) begin
        if (reset || !wr_en) begin
            fin  <= 1'b0;
            wcnt <= 0;
        end else if (ini) begin
            if (wcnt == 4) fin <= 1'b1;
            else wcnt <= wcnt + 1;
        end else begin
            wcnt <= 0;
            fin  <= 1'b0;
        end
    end

    // Monitor: pop scoreboard on each iniciar rise, check hold and gaps
    always @(negedge clk) begin
        logic [15:0] e;
        if (done) done_cnt++;
        if (ini && !prev_ini) begin
            tx_cnt++;
            if (prev_busy) chk("gap_ge2", 32'(low_cnt >= 2), 1);
            if (exp_q.size() == 0) begin
                chk("unexpected_tx", {24'd0, dir}, 32'hFFFF);
            end else begin
                e = exp_q.pop_front();
                chk("tx_dir", {24'd0, dir}, {24'd0, e[15:8]});
                chk("tx_dato", {24'd0, dato}, {24'd0, e[7:0]});
            end
            cap_dir  = dir;
            cap_dato = dato;
            run = 1;
        end else if (ini) begin
            run++;
            chk("hold_dir", {24'd0, dir}, {24'd0, cap_dir});
            chk("hold_dato", {24'd0, dato}, {24'd0, cap_dato});
        end
        if (!ini && prev_ini) last_run = run;
        low_cnt   = ini ? 0 : low_cnt + 1;
        prev_ini  = ini;
        prev_busy = busy;
    end

    task automatic push_exp(input logic [1:0] m);
        logic [7:0] a [0:8];
        logic [7:0] d [0:8];
        int lo, hi;
        a = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26,
              8'h41, 8'h42, 8'h43};
        d = '{seg, min, hor, dia, mes, ani, tseg, tmin, thor};
        lo = (m == 2'b01) ? 6 : 0;
        hi = (m == 2'b00) ? 5 : 8;
        for (int i = lo; i <= hi; i++) exp_q.push_back({a[i], d[i]});
    endtask

    task automatic do_start(input logic [1:0] m, input string tag);
        @(negedge clk);
        mode  = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_lat_ini"}, {31'd0, ini}, 1);
        chk({tag, "_lat_busy"}, {31'd0, busy}, 1);
        chk({tag, "_err_clr"}, {31'd0, err}, 0);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            chk({tag, "_done_timeout"}, 0, 1);
        end else begin
            chk({tag, "_busy_at_done"}, {31'd0, busy}, 0);
            @(negedge clk);
            chk({tag, "_done_1cyc"}, {31'd0, done}, 0);
        end
    endtask

    task automatic set_data(input logic [7:0] v);
        {seg, min, hor, dia, mes, ani} = {6{v}};
        {tseg, tmin, thor} = {3{v}};
    endtask

    task automatic load_defaults();
        seg = 8'h30; min = 8'h45; hor = 8'h12;
        dia = 8'h25; mes = 8'h12; ani = 8'h16;
        tseg = 8'h10; tmin = 8'h05; thor = 8'h00;
    endtask

    initial begin
        int base, dbase, n;
        reset = 1'b1;
        start = 1'b0;
        mode  = 2'b00;
        wr_en = 1'b1;
        load_defaults();
        repeat (3) @(negedge clk);
        chk("rst_ini", {31'd0, ini}, 0);
        chk("rst_dir", {24'd0, dir}, 0);
        chk("rst_dato", {24'd0, dato}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_err", {31'd0, err}, 0);
        reset = 1'b0;
        @(negedge clk);

        // Mode 00: six date/time writes
        base = tx_cnt; dbase = done_cnt;
        push_exp(2'b00);
        do_start(2'b00, "m00");
        wait_done("m00");
        chk("m00_txcnt", tx_cnt - base, 6);
        chk("m00_donecnt", done_cnt - dbase, 1);
        chk("m00_err", {31'd0, err}, 0);
        chk("m00_q_empty", exp_q.size(), 0);
        chk("m00_dir_idle", {24'd0, dir}, 0);

        // Mode 01: three timer writes
        base = tx_cnt;
        push_exp(2'b01);
        do_start(2'b01, "m01");
        wait_done("m01");
        chk("m01_txcnt", tx_cnt - base, 3);
        chk("m01_q_empty", exp_q.size(), 0);

        // Mode 10 with data scrambled after start and extra starts
        base = tx_cnt; dbase = done_cnt;
        push_exp(2'b10);
        do_start(2'b10, "m10");
        set_data(8'hFF);
        for (int k = 0; k < 3; k++) begin
            repeat (7) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_done("m10");
        chk("m10_txcnt", tx_cnt - base, 9);
        chk("m10_donecnt", done_cnt - dbase, 1);
        chk("m10_q_empty", exp_q.size(), 0);
        repeat (5) @(negedge clk);
        chk("m10_no_extra", tx_cnt - base, 9);
        load_defaults();

        // Timeout: writer silent
        wr_en = 1'b0;
        base = tx_cnt;
        push_exp(2'b00);
        n = 0;
        do_start(2'b00, "to");
        wait_done("to");
        chk("to_run", last_run, 20);
        chk("to_err", {31'd0, err}, 1);
        chk("to_busy", {31'd0, busy}, 0);
        chk("to_ini", {31'd0, ini}, 0);
        chk("to_dir", {24'd0, dir}, 0);
        chk("to_txcnt", tx_cnt - base, 1);
        exp_q.delete();
        wr_en = 1'b1;
        @(negedge clk);
        push_exp(2'b01);
        do_start(2'b01, "after_to");
        wait_done("after_to");
        chk("after_to_err", {31'd0, err}, 0);

        // Reserved mode
        base = tx_cnt;
        @(negedge clk);
        mode  = 2'b11;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("m11_done", {31'd0, done}, 1);
        chk("m11_err", {31'd0, err}, 1);
        chk("m11_busy", {31'd0, busy}, 0);
        chk("m11_ini", {31'd0, ini}, 0);
        @(negedge clk);
        chk("m11_done_1cyc", {31'd0, done}, 0);
        repeat (3) @(negedge clk);
        chk("m11_no_tx", tx_cnt - base, 0);

        // Reset during third transaction, then fresh burst
        base = tx_cnt;
        push_exp(2'b10);
        do_start(2'b10, "rst1");
        n = 0;
        while (tx_cnt - base < 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("rst_reach3", tx_cnt - base, 3);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_ini", {31'd0, ini}, 0);
        chk("mid_rst_busy", {31'd0, busy}, 0);
        chk("mid_rst_dir", {24'd0, dir}, 0);
        chk("mid_rst_dato", {24'd0, dato}, 0);
        chk("mid_rst_done", {31'd0, done}, 0);
        reset = 1'b0;
        exp_q.delete();
        repeat (3) @(negedge clk);
        base = tx_cnt;
        push_exp(2'b10);
        do_start(2'b10, "rst2");
        wait_done("rst2");
        chk("rst2_txcnt", tx_cnt - base, 9);
        chk("rst2_q_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
